// File: rtl/dlsc_demosaic_vng6_seq.sv
// Phase sequencer for the VNG 6-phase demosaic datapath: steps st 0..11 per job,
// tracks the column, and emits one completion token per job after LAT cycles.
module dlsc_demosaic_vng6_seq #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned XB    = 10,
    parameter int unsigned LAT   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [3:0]    st,
    output logic          st_en,
    output logic          st_first,
    output logic          st_last,
    output logic [XB-1:0] col,
    output logic          done_valid,
    input  logic          done_ready,
    output logic [XB-1:0] done_col,
    output logic          done_row_end
);

    localparam logic [3:0]    ST_LAST = 4'd11;
    localparam logic [XB-1:0] COL_MAX = XB'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    st_q, st_d;
    logic          st_en_q, st_en_d;
    logic          st_first_q, st_first_d;
    logic          st_last_q, st_last_d;
    logic [XB-1:0] col_q, col_d;
    logic [XB-1:0] cnt_q, cnt_d;
    logic          done_valid_q, done_valid_d;
    logic [XB-1:0] done_col_q, done_col_d;
    logic          done_row_end_q, done_row_end_d;

    logic          launch_ok;
    logic          accept;
    logic          launch;
    logic [XB-1:0] launch_col;
    logic          launch_end;
    logic          tail_v;
    logic [XB-1:0] tail_col;
    logic          tail_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            st_q           <= '0;
            st_en_q        <= 1'b0;
            st_first_q     <= 1'b0;
            st_last_q      <= 1'b0;
            col_q          <= '0;
            cnt_q          <= '0;
            done_valid_q   <= 1'b0;
            done_col_q     <= '0;
            done_row_end_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            st_q           <= st_d;
            st_en_q        <= st_en_d;
            st_first_q     <= st_first_d;
            st_last_q      <= st_last_d;
            col_q          <= col_d;
            cnt_q          <= cnt_d;
            done_valid_q   <= done_valid_d;
            done_col_q     <= done_col_d;
            done_row_end_q <= done_row_end_d;
        end
    end

    always_comb begin
        launch_ok = !done_valid_q || done_ready;
        case (state_q)
            S_IDLE:  in_ready = rst_n;
            S_RUN:   in_ready = rst_n && (st_q == ST_LAST) && launch_ok;
            S_WAIT:  in_ready = rst_n && launch_ok;
            default: in_ready = 1'b0;
        endcase
        accept  = in_valid && in_ready;
        launch  = 1'b0;
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RUN;
            end
            S_RUN: begin
                if (st_q == ST_LAST) begin
                    if (launch_ok) begin
                        launch  = 1'b1;
                        state_d = accept ? S_RUN : S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (launch_ok) begin
                    launch  = 1'b1;
                    state_d = accept ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        st_d  = st_q;
        col_d = col_q;
        cnt_d = cnt_q;
        if (accept) begin
            st_d  = '0;
            col_d = cnt_q;
            cnt_d = (cnt_q == COL_MAX) ? '0 : cnt_q + XB'(1);
        end else if (state_q == S_RUN && st_q != ST_LAST) begin
            st_d = st_q + 4'd1;
        end
        st_en_d    = (state_d == S_RUN);
        st_first_d = st_en_d && (st_d == 4'd0);
        st_last_d  = st_en_d && (st_d == ST_LAST);

        launch_col = col_q;
        launch_end = (col_q == COL_MAX);

        // A launch only happens into a free or freeing done slot, so tail never collides.
        done_valid_d   = done_valid_q && !done_ready;
        done_col_d     = done_col_q;
        done_row_end_d = done_row_end_q;
        if (tail_v) begin
            done_valid_d   = 1'b1;
            done_col_d     = tail_col;
            done_row_end_d = tail_end;
        end
    end

    // LAT-1 delay stages sit between the launch and the done register.
    if (LAT == 1) begin : g_direct
        assign tail_v   = launch;
        assign tail_col = launch_col;
        assign tail_end = launch_end;
    end else begin : g_pipe
        logic          dl_v_q   [LAT-1];
        logic          dl_v_d   [LAT-1];
        logic [XB-1:0] dl_col_q [LAT-1];
        logic [XB-1:0] dl_col_d [LAT-1];
        logic          dl_end_q [LAT-1];
        logic          dl_end_d [LAT-1];

        always_comb begin
            dl_v_d[0]   = launch;
            dl_col_d[0] = launch_col;
            dl_end_d[0] = launch_end;
            for (int unsigned i = 1; i < LAT - 1; i++) begin
                dl_v_d[i]   = dl_v_q[i-1];
                dl_col_d[i] = dl_col_q[i-1];
                dl_end_d[i] = dl_end_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < LAT - 1; i++) begin
                    dl_v_q[i]   <= 1'b0;
                    dl_col_q[i] <= '0;
                    dl_end_q[i] <= 1'b0;
                end
            end else begin
                dl_v_q   <= dl_v_d;
                dl_col_q <= dl_col_d;
                dl_end_q <= dl_end_d;
            end
        end

        assign tail_v   = dl_v_q[LAT-2];
        assign tail_col = dl_col_q[LAT-2];
        assign tail_end = dl_end_q[LAT-2];
    end

    assign st           = st_q;
    assign st_en        = st_en_q;
    assign st_first     = st_first_q;
    assign st_last      = st_last_q;
    assign col          = col_q;
    assign done_valid   = done_valid_q;
    assign done_col     = done_col_q;
    assign done_row_end = done_row_end_q;

endmodule

// File: tb/tb_dlsc_demosaic_vng6_seq.sv
// Scoreboard bench for dlsc_demosaic_vng6_seq: two instances (LAT=1/WIDTH=1024 and
// LAT=8/WIDTH=7) share stimulus; each has its own job model and token queue.
module tb_dlsc_demosaic_vng6_seq;

    localparam int XB = 10;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   in_valid;
    logic   done_ready;
    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    bit     end_chk = 1'b0;

    typedef struct {
        int     col;
        bit     rend;
        longint arr;
    } tok_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int g, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] cycle %0d: got %0d expected %0d", nm, g, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned W = (g == 0) ? 1024 : 7;
        localparam int unsigned L = (g == 0) ? 1 : 8;

        logic          in_ready, st_en, st_first, st_last, done_valid, done_row_end;
        logic [3:0]    st;
        logic [XB-1:0] col, done_col;

        dlsc_demosaic_vng6_seq #(.WIDTH(W), .XB(XB), .LAT(L)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid     (in_valid),
            .in_ready     (in_ready),
            .st           (st),
            .st_en        (st_en),
            .st_first     (st_first),
            .st_last      (st_last),
            .col          (col),
            .done_valid   (done_valid),
            .done_ready   (done_ready),
            .done_col     (done_col),
            .done_row_end (done_row_end)
        );

        tok_t q[$];
        int   exp_phase = -1;
        int   exp_col   = 0;
        int   jobcnt    = 0;
        int   pend_col  = 0;
        bit   pend_end  = 1'b0;
        bit   waiting   = 1'b0;
        bit   prev_dv   = 1'b0;
        bit   prev_hs   = 1'b0;
        bit   chk_rst   = 1'b0;
        bit   end_done  = 1'b0;

        always @(negedge clk) begin : mon
            bit   lok;
            bit   ready_m;
            bit   arrival;
            tok_t t;

            if (chk_rst) begin
                check("reset_outputs", g,
                      {st, st_en, st_first, st_last, col, done_valid, done_col, done_row_end}, 0);
                chk_rst = 1'b0;
            end

            check("st_en", g, st_en, exp_phase >= 0);
            if (exp_phase >= 0) begin
                check("st", g, st, exp_phase);
                check("st_first_last", g, {st_first, st_last}, {exp_phase == 0, exp_phase == 11});
                check("col", g, col, exp_col);
            end

            arrival = done_valid && (!prev_dv || prev_hs);
            if (q.size() != 0 && q[0].arr <= cyc)
                check("token_due", g, arrival, 1);
            if (arrival) begin
                check("token_expected", g, q.size() != 0, 1);
                if (q.size() != 0) begin
                    t = q.pop_front();
                    check("done_col", g, done_col, t.col);
                    check("done_row_end", g, done_row_end, t.rend);
                    check("done_latency", g, cyc, t.arr);
                end
            end else if (q.size() != 0 && q[0].arr <= cyc) begin
                void'(q.pop_front());
            end

            lok     = !done_valid || done_ready;
            ready_m = rst_n && ((exp_phase < 0 && !waiting) || ((exp_phase == 11 || waiting) && lok));
            check("in_ready", g, in_ready, ready_m);

            if (!rst_n) begin
                q.delete();
                exp_phase = -1;
                waiting   = 1'b0;
                jobcnt    = 0;
                prev_dv   = 1'b0;
                prev_hs   = 1'b0;
                chk_rst   = 1'b1;
            end else begin
                // Job finishing phase 11 (or parked) launches its token once the slot frees.
                if ((exp_phase == 11 || waiting) && lok) begin
                    q.push_back('{pend_col, pend_end, cyc + L});
                    waiting = 1'b0;
                end else if (exp_phase == 11) begin
                    waiting = 1'b1;
                end
                prev_dv = done_valid;
                prev_hs = done_valid && done_ready;
                if (in_valid && ready_m) begin
                    exp_phase = 0;
                    exp_col   = jobcnt % W;
                    pend_col  = exp_col;
                    pend_end  = (exp_col == W - 1);
                    jobcnt++;
                end else if (exp_phase >= 0 && exp_phase < 11) begin
                    exp_phase++;
                end else begin
                    exp_phase = -1;
                end
            end

            if (end_chk && !end_done) begin
                check("queue_drained", g, q.size(), 0);
                check("left_waiting", g, waiting, 0);
                end_done = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        done_ready = 1'b1;
        step(3);
        rst_n = 1'b1;

        // single job
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(20);

        // 2048 back-to-back jobs from a fresh column counter
        rst_n = 1'b0;
        step(1);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        step(2048 * 12);
        in_valid = 1'b0;
        step(20);

        // consumer stall during a stream
        in_valid = 1'b1;
        step(30);
        done_ready = 1'b0;
        step(30);
        done_ready = 1'b1;
        step(40);
        in_valid = 1'b0;
        step(20);

        // reset at st==5 with a token in flight on the LAT=8 instance
        in_valid = 1'b1;
        step(14);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (g_cfg[1].st_en && g_cfg[1].st == 4'd5) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        check("reach_st5", 1, found, 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step(1);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(30);

        // park a job in WAIT, then free the slot and offer a job in the same cycle
        done_ready = 1'b0;
        in_valid   = 1'b1;
        step(30);
        in_valid = 1'b0;
        step(10);
        in_valid   = 1'b1;
        done_ready = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(30);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            done_ready = ($urandom_range(0, 9) < 6);
            rst_n      = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        done_ready = 1'b1;
        step(40);

        end_chk = 1'b1;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dlsc_demosaic_vng6_seq.md
# dlsc_demosaic_vng6_seq

Phase sequencer for the VNG 6-phase demosaic datapath. It accepts one pixel-column job per input handshake and steps the 4-bit phase index `st` through 0..11 to drive the per-phase coefficient ROMs and the accumulation stages. It tracks the column position within a row. After a configurable pipeline latency it emits one completion token per job on a valid/ready handshake. Backpressure on the completion port stalls phase sequencing, so no token is ever dropped.

## Interface
- `WIDTH`, default 1024: pixels per row; legal range 2..2^XB.
- `XB`, default 10: column counter width.
- `LAT`, default 1: cycles from the `st==11` cycle to the token reaching the done register; legal range 1..8.

- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  job offered.
- `in_ready`  out  1  job accepted when `in_valid && in_ready`; combinational.
- `st`  out  4  current phase index 0..11; registered.
- `st_en`  out  1  `st` is an active phase; registered.
- `st_first`  out  1  `st_en && st==0`; registered.
- `st_last`  out  1  `st_en && st==11`; registered.
- `col`  out  XB  column of the job currently in phase; registered.
- `done_valid`  out  1  completion token present; registered.
- `done_ready`  in  1  consumer takes the token.
- `done_col`  out  XB  column of the completed job.
- `done_row_end`  out  1  the completed job was column WIDTH-1.

## Operation
- States:
  - IDLE: no job.
  - RUN: phases are stepping.
  - WAIT: phase 11 is done but the token cannot launch yet.
- `launch_ok = !done_valid || done_ready`.
- `in_ready = rst_n && (IDLE || (RUN && st==11 && launch_ok) || (WAIT && launch_ok))`.
- Accepting a job:
  - Next state is RUN.
  - `st` = 0, `st_en` = 1.
  - `col` loads the column counter, which then increments. The counter wraps from WIDTH-1 to 0.
- RUN with `st` < 11: `st` increments by 1 each cycle.
- RUN with `st==11`:
  - If `launch_ok`: launch a token carrying (`col`, `col==WIDTH-1`) into the LAT-stage delay line. Then go to RUN at `st=0` if a job is accepted, else go to IDLE with `st_en=0` and `st` held at 11.
  - If not `launch_ok`: go to WAIT with `st_en=0` and `st` held at 11; no token is launched.
- WAIT: when `launch_ok` goes high, launch the token. In the same cycle, accept a new job if `in_valid` (go to RUN), else go to IDLE.
- Done register:
  - Loads from the delay-line tail.
  - Clears on `done_valid && done_ready` unless a new token arrives in the same cycle.
  - Because LAT < 12 and a launch requires a free or freeing slot, the delay line holds at most one token and never collides with an occupied done register.
- `st_first`, `st_last` and `col` are decoded from the next-state values, so they align with `st`.
- Reset (`rst_n` low at a clock edge), including mid-job:
  - State returns to IDLE.
  - `st`=0, `st_en`=0, `st_first`=0, `st_last`=0, `col`=0.
  - Column counter = 0.
  - Delay line is flushed.
  - `done_valid`=0, `done_col`=0, `done_row_end`=0.
  - `in_ready`=0 while `rst_n` is low.

## Timing
- Job accepted at cycle t: `st_en` is high from t+1 to t+12 with `st`=0..11. `st_first` is high at t+1; `st_last` is high at t+12.
- Token launched at cycle c (the `st==11` cycle, or the WAIT exit cycle): `done_valid` goes high at c+LAT.
- Back-to-back jobs (`in_valid` held, `done_ready` held): `st` runs 0..11,0..11 with no bubble. Throughput is one job per 12 cycles.
- Downstream ROM output lags `st` by one cycle; the default LAT=1 aligns `done_valid` with the ROM word for phase 11.

## Test plan
- Reset, then a single job with `done_ready`=1 → `st` counts 0..11 over cycles 1..12 after acceptance, `st_last` is high at cycle 12, `done_valid` pulses at cycle 13 with `done_col`=0, and the block returns to IDLE.
- 2048 back-to-back jobs with WIDTH=1024 → no gap in `st_en`. `done_col` sequence is 0..1023,0..1023. `done_row_end` is high exactly twice, at col 1023.
- `done_ready`=0 for 30 cycles during a stream → the job after the first token enters WAIT at `st==11` with `st_en`=0 and `in_ready`=0. On `done_ready`=1, exactly one token is consumed and the next token follows LAT cycles later. No token is lost or duplicated.
- LAT=8, jobs back-to-back → each `done_valid` asserts 8 cycles after its `st_last`. Tokens remain strictly in order.
- `rst_n` low at `st`=5 while a token is in flight → the cycle after reset, all outputs are 0. No stale token appears, and the next job gets `col`=0.
- `in_valid` asserts in the same cycle `done_ready` frees a held token in WAIT → the job is accepted that cycle and `st`=0 appears on the next cycle.
